// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: pointer-width helpers and the Gray/binary conversions.
package fifo_pkg;

    // Pointer helpers work on a wide container; callers zero-extend in and truncate out.
    localparam int unsigned MAX_PTR_W = 32;

    typedef logic [MAX_PTR_W-1:0] wide_ptr_t;

    typedef enum logic {
        ST_EMPTY    = 1'b0,
        ST_NONEMPTY = 1'b1
    } rd_state_e;

    function automatic wide_ptr_t bin2gray(input wide_ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // Leading zeros from zero-extension leave the low bits unaffected.
    function automatic wide_ptr_t gray2bin(input wide_ptr_t g);
        wide_ptr_t b;
        b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop vector synchronizer for a Gray-coded pointer crossing clock domains.
module ptr_sync #(
    parameter int unsigned WIDTH  = 7,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the async FIFO: read pointers, RAM read strobes,
// registered empty/almost-empty/occupancy flags and underflow detection.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AE_THRESH   = 4
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH:0]   wptr_gray,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  mem_ren,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_count,
    output logic                  underflow
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("fifo_rd_ctrl: SYNC_STAGES must be 2..4");
    end
    if (DATA_WIDTH == 0) begin : g_bad_dw
        $error("fifo_rd_ctrl: DATA_WIDTH must be non-zero");
    end

    ptr_t      wq;
    ptr_t      wq_bin;
    ptr_t      rbin_q,  rbin_d;
    ptr_t      rgray_q, rgray_d;
    ptr_t      count_q, count_d;
    rd_state_e state_q, state_d;
    logic      ae_q, ae_d;
    logic      underflow_q, underflow_d;
    logic      rd_valid_q;
    logic      pop;

    ptr_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk_i  (rclk),
        .rst_ni (rrst_n),
        .d_i    (wptr_gray),
        .q_o    (wq)
    );

    // Next-state pointers and flags; flags derive from next-state values so
    // the last pop asserts empty on the same edge it retires.
    always_comb begin
        pop         = 1'b0;
        wq_bin      = '0;
        rbin_d      = rbin_q;
        rgray_d     = rgray_q;
        count_d     = count_q;
        state_d     = state_q;
        ae_d        = ae_q;
        underflow_d = 1'b0;

        pop         = rd_en & (state_q == ST_NONEMPTY);
        wq_bin      = PTR_W'(gray2bin(MAX_PTR_W'(wq)));
        rbin_d      = rbin_q + PTR_W'(pop);
        rgray_d     = PTR_W'(bin2gray(MAX_PTR_W'(rbin_d)));
        count_d     = wq_bin - rbin_d;
        state_d     = (rgray_d == wq) ? ST_EMPTY : ST_NONEMPTY;
        ae_d        = MAX_PTR_W'(count_d) <= MAX_PTR_W'(AE_THRESH);
        underflow_d = rd_en & (state_q == ST_EMPTY);
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q      <= '0;
            rgray_q     <= '0;
            count_q     <= '0;
            state_q     <= ST_EMPTY;
            ae_q        <= 1'b1;
            underflow_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            rbin_q      <= rbin_d;
            rgray_q     <= rgray_d;
            count_q     <= count_d;
            state_q     <= state_d;
            ae_q        <= ae_d;
            underflow_q <= underflow_d;
            rd_valid_q  <= pop;
        end
    end

    assign rptr_gray    = rgray_q;
    assign raddr        = rbin_q[ADDR_WIDTH-1:0];
    assign mem_ren      = pop;
    assign rd_valid     = rd_valid_q;
    assign empty        = (state_q == ST_EMPTY);
    assign almost_empty = ae_q;
    assign rd_count     = count_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a queue-based read-address scoreboard.
module tb_fifo_rd_ctrl;

    logic       rclk = 1'b0;
    logic       rrst_n;
    logic       rd_en;
    logic [3:0] wptr_gray;
    logic [3:0] rptr_gray;
    logic [2:0] raddr;
    logic       mem_ren;
    logic       rd_valid;
    logic       empty;
    logic       almost_empty;
    logic [3:0] rd_count;
    logic       underflow;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_pops = 0;
    int n_rdv  = 0;

    logic [2:0] exp_q[$];
    logic [2:0] wrap_addr[4] = '{3'd6, 3'd7, 3'd0, 3'd1};
    logic [3:0] wrap_gray[4] = '{4'b1001, 4'b1000, 4'b0000, 4'b0001};

    fifo_rd_ctrl #(
        .DATA_WIDTH  (8),
        .ADDR_WIDTH  (3),
        .SYNC_STAGES (2),
        .AE_THRESH   (2)
    ) dut (
        .rclk         (rclk),
        .rrst_n       (rrst_n),
        .rd_en        (rd_en),
        .wptr_gray    (wptr_gray),
        .rptr_gray    (rptr_gray),
        .raddr        (raddr),
        .mem_ren      (mem_ren),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_count     (rd_count),
        .underflow    (underflow)
    );

    always #5 rclk = ~rclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next();
        @(posedge rclk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge rclk);
    endtask

    task automatic push_exp(input logic [2:0] a);
        exp_q.push_back(a);
        n_pops++;
    endtask

    // Monitor: every RAM read strobe must match the next expected address.
    task automatic monitor();
        forever begin
            @(negedge rclk);
            if (mem_ren) begin
                if (exp_q.size() == 0) chk("mem_ren_unexpected", 32'(mem_ren), 32'd0);
                else                   chk("raddr", 32'(raddr), 32'(exp_q.pop_front()));
            end
            if (rd_valid) n_rdv++;
        end
    endtask

    initial begin
        rrst_n    = 1'b0;
        rd_en     = 1'b1;
        wptr_gray = 4'b0000;
        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: bench exceeded time limit");
                $fatal(1);
            end
        join_none

        // Reset with rd_en high
        at_neg();
        chk("rst_empty",     32'(empty),        32'd1);
        chk("rst_ae",        32'(almost_empty), 32'd1);
        chk("rst_count",     32'(rd_count),     32'd0);
        chk("rst_mem_ren",   32'(mem_ren),      32'd0);
        chk("rst_underflow", 32'(underflow),    32'd0);
        chk("rst_rptr",      32'(rptr_gray),    32'd0);
        next(); next();
        rrst_n = 1'b1;
        rd_en  = 1'b0;

        // Sync latency, then a single pop
        next();
        wptr_gray = 4'b0001;
        next(); next();
        at_neg();
        chk("sync_empty_still_high", 32'(empty), 32'd1);
        next();
        at_neg();
        chk("sync_empty_low", 32'(empty),        32'd0);
        chk("sync_count",     32'(rd_count),     32'd1);
        chk("sync_ae",        32'(almost_empty), 32'd1);
        next();
        rd_en = 1'b1;
        push_exp(3'd0);
        at_neg();
        chk("single_mem_ren", 32'(mem_ren), 32'd1);
        next();
        rd_en = 1'b0;
        at_neg();
        chk("single_rd_valid", 32'(rd_valid),  32'd1);
        chk("single_empty",    32'(empty),     32'd1);
        chk("single_count",    32'(rd_count),  32'd0);
        chk("single_rptr",     32'(rptr_gray), 32'd1);

        // Fill then drain from a fresh reset
        next();
        rrst_n    = 1'b0;
        wptr_gray = 4'b1100;
        next();
        rrst_n = 1'b1;
        repeat (4) next();
        at_neg();
        chk("fill_count", 32'(rd_count),     32'd8);
        chk("fill_ae",    32'(almost_empty), 32'd0);
        chk("fill_empty", 32'(empty),        32'd0);
        for (int k = 0; k < 8; k++) begin
            next();
            rd_en = 1'b1;
            push_exp(3'(k));
            at_neg();
            chk("drain_count", 32'(rd_count),     32'(8 - k));
            chk("drain_ae",    32'(almost_empty), 32'((8 - k) <= 2));
            chk("drain_empty", 32'(empty),        32'd0);
        end
        next();
        rd_en = 1'b0;
        at_neg();
        chk("drain_end_empty", 32'(empty),        32'd1);
        chk("drain_end_count", 32'(rd_count),     32'd0);
        chk("drain_end_ae",    32'(almost_empty), 32'd1);
        chk("drain_end_rptr",  32'(rptr_gray),    32'b1100);

        // Advance read pointer to 14, then wrap through zero
        next();
        wptr_gray = 4'b1001;
        repeat (4) next();
        at_neg();
        chk("pre_wrap_count", 32'(rd_count), 32'd6);
        for (int k = 0; k < 6; k++) begin
            next();
            rd_en = 1'b1;
            push_exp(3'(k));
            at_neg();
        end
        next();
        rd_en = 1'b0;
        at_neg();
        chk("pre_wrap_empty", 32'(empty),     32'd1);
        chk("pre_wrap_rptr",  32'(rptr_gray), 32'b1001);
        next();
        wptr_gray = 4'b0011;
        repeat (4) next();
        at_neg();
        chk("wrap_count", 32'(rd_count),     32'd4);
        chk("wrap_ae",    32'(almost_empty), 32'd0);
        for (int k = 0; k < 4; k++) begin
            next();
            rd_en = 1'b1;
            push_exp(wrap_addr[k]);
            at_neg();
            chk("wrap_rptr", 32'(rptr_gray), 32'(wrap_gray[k]));
        end
        next();
        rd_en = 1'b0;
        at_neg();
        chk("wrap_end_rptr",  32'(rptr_gray), 32'b0011);
        chk("wrap_end_empty", 32'(empty),     32'd1);

        // Underflow: three cycles of rd_en while empty
        for (int k = 0; k < 3; k++) begin
            next();
            rd_en = 1'b1;
            at_neg();
            chk("uf_mem_ren",   32'(mem_ren),   32'd0);
            chk("uf_underflow", 32'(underflow), 32'(k > 0));
        end
        next();
        rd_en = 1'b0;
        at_neg();
        chk("uf_third",     32'(underflow), 32'd1);
        next();
        at_neg();
        chk("uf_cleared",   32'(underflow), 32'd0);
        chk("uf_rptr_held", 32'(rptr_gray), 32'b0011);
        chk("uf_count",     32'(rd_count),  32'd0);

        // Reset the cycle after a pop: in-flight rd_valid dropped
        next();
        wptr_gray = 4'b0110;
        repeat (4) next();
        at_neg();
        chk("mid_count", 32'(rd_count), 32'd2);
        chk("mid_empty", 32'(empty),    32'd0);
        next();
        rd_en = 1'b1;
        push_exp(3'd2);
        at_neg();
        next();
        rd_en  = 1'b0;
        rrst_n = 1'b0;
        at_neg();
        chk("mid_rd_valid", 32'(rd_valid),     32'd0);
        chk("mid_empty_rst", 32'(empty),       32'd1);
        chk("mid_rptr",     32'(rptr_gray),    32'd0);
        chk("mid_count_rst", 32'(rd_count),    32'd0);
        chk("mid_ae",       32'(almost_empty), 32'd1);
        next();
        rrst_n = 1'b1;
        repeat (4) next();
        at_neg();
        chk("post_rst_count", 32'(rd_count), 32'd4);
        chk("post_rst_empty", 32'(empty),    32'd0);

        next();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("rd_valid_pulses",    32'(n_rdv),        32'(n_pops - 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
